// File: rtl/zero_pkg.sv
// Shared definitions for the out/in channel ring buffers: word width, word type
// and the position wrap rule.
package zero_pkg;

    localparam int MemoryElementWidth = 12;

    typedef logic [MemoryElementWidth-1:0] word_t;

    // Advance a ring position; depth need not be a power of two.
    function automatic logic [31:0] next_pos(input logic [31:0] pos, input logic [31:0] depth);
        return (pos == depth - 32'd1) ? 32'd0 : pos + 32'd1;
    endfunction

endpackage

// File: rtl/out_channel_arbiter_if.sv
// Bundle of requester-side and consumer-side signals of the out channel arbiter.
// Handshakes: a requester word is taken at the edge where req[i]&grant[i]; the
// consumer pops at the edge where outValid&outReady. req is held until granted.
interface out_channel_arbiter_if #(
    parameter int NReq = 4,
    parameter int NOut = 100
);
    import zero_pkg::*;

    logic [NReq-1:0]                    req;
    logic [NReq*MemoryElementWidth-1:0] reqData;
    logic [NReq-1:0]                    grant;
    logic                               outValid;
    word_t                              outData;
    logic                               outReady;
    logic [$clog2(NOut+1)-1:0]          outCount;
    logic                               full;
    logic [31:0]                        outMemPos;

    modport slave (
        input  req, reqData, outReady,
        output grant, outValid, outData, outCount, full, outMemPos
    );

    modport master (
        output req, reqData, outReady,
        input  grant, outValid, outData, outCount, full, outMemPos
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr_i,
// wrapping at NReq. Produces nothing unless enable_i is high.
module rr_arbiter #(
    parameter int NReq = 4,
    parameter int IW   = (NReq > 1) ? $clog2(NReq) : 1
) (
    input  logic [NReq-1:0] req_i,
    input  logic [IW-1:0]   rr_ptr_i,
    input  logic            enable_i,
    output logic [NReq-1:0] grant_o,
    output logic [IW-1:0]   winner_o
);

    int   idx;
    logic found;

    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NReq; k++) begin
            idx = (int'(rr_ptr_i) + k) % NReq;
            if (enable_i && !found && req_i[idx]) begin
                found         = 1'b1;
                grant_o[idx]  = 1'b1;
                winner_o      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/out_channel_arbiter.sv
// Out channel ring buffer shared by NReq engines: round-robin write arbitration,
// one word stored per cycle, FIFO drain through a valid/ready consumer port.
module out_channel_arbiter
    import zero_pkg::*;
#(
    parameter int NOut = 100,
    parameter int NReq = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    out_channel_arbiter_if.slave bus
);

    localparam int PW = (NOut > 1) ? $clog2(NOut) : 1;
    localparam int CW = $clog2(NOut + 1);
    localparam int IW = (NReq > 1) ? $clog2(NReq) : 1;

    word_t           mem_q [NOut];
    logic [PW-1:0]   rd_pos_q, rd_pos_d;
    logic [PW-1:0]   wr_pos_q, wr_pos_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     mem_pos_q, mem_pos_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;

    logic            full;
    logic            out_valid;
    logic            pop;
    logic            arb_en;
    logic            wr_en;
    logic [NReq-1:0] grant;
    logic [IW-1:0]   winner;
    word_t           wr_word;

    assign full      = (count_q == CW'(NOut));
    assign out_valid = !reset && (count_q != '0);
    assign pop       = out_valid && bus.outReady;
    // A pop at the same edge frees the slot, so a full buffer may still accept.
    assign arb_en    = !reset && (!full || pop);

    rr_arbiter #(.NReq(NReq), .IW(IW)) u_rr_arbiter (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .enable_i (arb_en),
        .grant_o  (grant),
        .winner_o (winner)
    );

    assign wr_en   = |grant;
    assign wr_word = bus.reqData[int'(winner)*MemoryElementWidth +: MemoryElementWidth];

    assign bus.grant     = grant;
    assign bus.outValid  = out_valid;
    assign bus.outData   = mem_q[rd_pos_q];
    assign bus.outCount  = count_q;
    assign bus.full      = full;
    assign bus.outMemPos = mem_pos_q;

    always_comb begin
        rd_pos_d  = rd_pos_q;
        wr_pos_d  = wr_pos_q;
        count_d   = count_q;
        mem_pos_d = mem_pos_q;
        rr_ptr_d  = rr_ptr_q;
        if (wr_en) begin
            wr_pos_d  = PW'(next_pos(32'(wr_pos_q), 32'(NOut)));
            mem_pos_d = mem_pos_q + 32'd1;
            rr_ptr_d  = IW'(next_pos(32'(winner), 32'(NReq)));
        end
        if (pop) begin
            rd_pos_d = PW'(next_pos(32'(rd_pos_q), 32'(NOut)));
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_pos_q  <= '0;
            wr_pos_q  <= '0;
            count_q   <= '0;
            mem_pos_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            rd_pos_q  <= rd_pos_d;
            wr_pos_q  <= wr_pos_d;
            count_q   <= count_d;
            mem_pos_q <= mem_pos_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // Storage is deliberately not reset; count/positions define what is live.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_pos_q] <= wr_word;
        end
    end

endmodule

// File: tb/tb_out_channel_arbiter.sv
// Bench for out_channel_arbiter: directed scenarios plus random traffic, all
// checked against a queue-based model of the buffer and round-robin rule.
module tb_out_channel_arbiter;
    import zero_pkg::*;

    localparam int NOut = 100;
    localparam int NReq = 4;
    localparam int W    = MemoryElementWidth;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    out_channel_arbiter_if #(.NReq(NReq), .NOut(NOut)) bus ();

    out_channel_arbiter #(.NOut(NOut), .NReq(NReq)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    word_t           exp_q[$];
    int unsigned     m_pos;
    int              m_rr;
    logic [NReq-1:0] last_grant;
    logic            obs_valid;
    word_t           obs_data;
    int              errors;
    int              checks;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected grant from the current inputs: first requester at or after the
    // round-robin pointer, only if a slot is free or being freed by a pop.
    function automatic logic [NReq-1:0] model_grant();
        logic [NReq-1:0] g;
        bit              space;
        g = '0;
        if (reset) return g;
        space = (exp_q.size() < NOut) || (bus.outReady && exp_q.size() > 0);
        if (!space) return g;
        for (int k = 0; k < NReq; k++) begin
            int i;
            i = (m_rr + k) % NReq;
            if (bus.req[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    // One clock: check outputs before the edge, advance the model at the edge.
    task automatic cycle();
        logic [NReq-1:0] eg;
        bit              pop;
        int              w;
        #1;
        eg  = model_grant();
        pop = !reset && bus.outReady && (exp_q.size() > 0);
        obs_valid = bus.outValid;
        obs_data  = bus.outData;
        check("grant", 32'(bus.grant), 32'(eg));
        check("out_valid", 32'(bus.outValid), (!reset && exp_q.size() > 0) ? 32'd1 : 32'd0);
        check("out_count", 32'(bus.outCount), exp_q.size());
        check("full", 32'(bus.full), (exp_q.size() == NOut) ? 32'd1 : 32'd0);
        check("out_mem_pos", bus.outMemPos, m_pos);
        if (!reset && exp_q.size() > 0) check("out_data", 32'(bus.outData), 32'(exp_q[0]));
        @(posedge clock);
        last_grant = eg;
        if (reset) begin
            exp_q.delete();
            m_pos = 0;
            m_rr  = 0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (eg != '0) begin
                w = 0;
                for (int i = 0; i < NReq; i++) if (eg[i]) w = i;
                exp_q.push_back(bus.reqData[w*W +: W]);
                m_pos++;
                m_rr = (w + 1) % NReq;
            end
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        bus.req      = '0;
        bus.outReady = 1'b0;
        reset        = 1'b1;
        cycle();
        reset        = 1'b0;
    endtask

    // Random requesters: a pending req is held until granted; no new requests
    // once 'limit' words have been accepted.
    task automatic drive_reqs(input int p, input int unsigned limit);
        for (int i = 0; i < NReq; i++) begin
            if (m_pos >= limit) begin
                bus.req[i] = 1'b0;
            end else if (last_grant[i] || !bus.req[i]) begin
                bus.req[i] = ($urandom_range(99) < p);
                bus.reqData[i*W +: W] = W'($urandom);
            end
        end
    endtask

    initial begin
        logic [NReq-1:0] g_seq [5];
        word_t           d_seq [5];
        int              budget;

        errors       = 0;
        checks       = 0;
        m_pos        = 0;
        m_rr         = 0;
        last_grant   = '0;
        bus.req      = '0;
        bus.reqData  = '0;
        bus.outReady = 1'b0;
        reset        = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        cycle();
        reset = 1'b0;

        // Idle after reset
        repeat (5) cycle();
        check("idle_count", 32'(bus.outCount), 32'd0);

        // Single writer
        bus.req = 4'b0001;
        bus.reqData[0 +: W] = W'(2);
        cycle();
        bus.req = '0;
        cycle();
        check("single_valid", 32'(obs_valid), 32'd1);
        check("single_data", 32'(obs_data), 32'd2);
        bus.outReady = 1'b1;
        cycle();
        bus.outReady = 1'b0;
        cycle();
        check("single_drained", 32'(obs_valid), 32'd0);

        // Four constant requesters, consumer always ready
        do_reset();
        for (int i = 0; i < NReq; i++) bus.reqData[i*W +: W] = W'(10 + i);
        bus.req      = 4'b1111;
        bus.outReady = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (c < 5) g_seq[c] = last_grant;
            if (c > 0) d_seq[c-1] = obs_data;
        end
        for (int c = 0; c < 5; c++) begin
            check("rr_grant_seq", 32'(g_seq[c]), 32'(1 << (c % NReq)));
            check("rr_data_seq", 32'(d_seq[c]), 32'(10 + (c % NReq)));
        end

        // Fill to full, then write while popping
        do_reset();
        bus.req = 4'b0001;
        for (int k = 0; k < NOut; k++) begin
            bus.reqData[0 +: W] = W'(100 + k);
            cycle();
        end
        bus.reqData[0 +: W] = W'(999);
        #1;
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_count", 32'(bus.outCount), 32'(NOut));
        check("fill_no_grant", 32'(bus.grant), 32'd0);
        cycle();
        bus.outReady = 1'b1;
        #1;
        check("full_pop_grant", 32'(bus.grant), 32'd1);
        check("full_first_out", 32'(bus.outData), 32'd100);
        cycle();
        check("full_pop_count", 32'(bus.outCount), 32'(NOut));
        bus.req      = '0;
        bus.outReady = 1'b0;

        // Wrap: 250 words in alternating write/pop bursts
        do_reset();
        budget = 0;
        while (m_pos < 250 && budget < 20000) begin
            bus.outReady = 1'b0;
            for (int b = $urandom_range(5, 40); b > 0; b--) begin
                drive_reqs(80, 250);
                cycle();
                budget++;
            end
            bus.outReady = 1'b1;
            for (int b = $urandom_range(5, 40); b > 0; b--) begin
                drive_reqs(30, 250);
                cycle();
                budget++;
            end
        end
        bus.req      = '0;
        bus.outReady = 1'b1;
        while (exp_q.size() > 0 && budget < 20000) begin
            cycle();
            budget++;
        end
        if (budget >= 20000) check("wrap_timeout", 32'd1, 32'd0);
        check("wrap_mem_pos", bus.outMemPos, 32'd250);
        check("wrap_empty", 32'(bus.outCount), 32'd0);
        bus.outReady = 1'b0;

        // Reset with 7 words buffered
        do_reset();
        bus.req = 4'b0100;
        for (int k = 0; k < 7; k++) begin
            bus.reqData[2*W +: W] = W'(50 + k);
            cycle();
        end
        bus.req = '0;
        check("pre_reset_count", 32'(bus.outCount), 32'd7);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("post_reset_count", 32'(bus.outCount), 32'd0);
        check("post_reset_valid", 32'(bus.outValid), 32'd0);
        bus.req = 4'b0001;
        bus.reqData[0 +: W] = W'(5);
        cycle();
        bus.req = '0;
        cycle();
        check("post_reset_first", 32'(obs_data), 32'd5);
        check("post_reset_first_valid", 32'(obs_valid), 32'd1);

        // Random traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            bus.outReady = ($urandom_range(99) < 45);
            drive_reqs(50, 32'hFFFF_FFFF);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
